// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped cache and its refill controller:
// controller states, address-field widths and address-field extraction helpers.
package cache_pkg;

   localparam int unsigned INDEX_WIDTH  = 4;
   localparam int unsigned OFFSET_WIDTH = 2;
   localparam int unsigned TAG_WIDTH    = 32 - INDEX_WIDTH - OFFSET_WIDTH;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEM_WAIT = 2'd1,
      FILL     = 2'd2,
      FLUSH    = 2'd3
   } state_t;

   // Results are returned zero-extended to 32 bits; callers narrow them to
   // their own field width, so a module with a non-default index width still
   // shares these helpers.
   function automatic logic [31:0] get_index(input logic [31:0] addr,
                                             input int unsigned iw = INDEX_WIDTH);
      return (addr >> OFFSET_WIDTH) & ((32'd1 << iw) - 32'd1);
   endfunction

   function automatic logic [31:0] get_tag(input logic [31:0] addr,
                                           input int unsigned iw = INDEX_WIDTH);
      return addr >> (OFFSET_WIDTH + iw);
   endfunction

endpackage

// File: rtl/cache_refill_ctrl.sv
// Miss-handling controller for the direct-mapped cache: refills a missing word
// from main memory and sequences full-cache invalidation sweeps.
module cache_refill_ctrl #(
   parameter int unsigned INDEX_WIDTH = 4,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned TAG_WIDTH   = 32 - INDEX_WIDTH - 2,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic                   iCLK,
   input  logic                   iRST,
   input  logic                   iReq,
   input  logic [31:0]            iAddress,
   input  logic                   iHit,
   input  logic                   iFlush,
   output logic                   oMemReq,
   output logic [31:0]            oMemAddr,
   input  logic                   iMemValid,
   input  logic [DATA_WIDTH-1:0]  iMemData,
   output logic                   oFillEn,
   output logic [INDEX_WIDTH-1:0] oFillIndex,
   output logic [TAG_WIDTH-1:0]   oFillTag,
   output logic [DATA_WIDTH-1:0]  oFillData,
   output logic                   oInvEn,
   output logic                   oRespValid,
   output logic [DATA_WIDTH-1:0]  oRespData,
   output logic                   oStall,
   output logic                   oError
);

   import cache_pkg::*;

   localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0]      WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);
   localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = '1;

   state_t                 state;
   state_t                 state_nx;
   logic [WAIT_W-1:0]      wait_cnt;
   logic [INDEX_WIDTH-1:0] flush_cnt;
   logic                   pending;
   logic [31:0]            addr_q;
   logic [DATA_WIDTH-1:0]  data_q;

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         flush_cnt <= '0;
         pending   <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (iFlush || pending) begin
                  pending   <= 1'b0;
                  flush_cnt <= '0;
               end else if (iReq && !iHit) begin
                  addr_q   <= iAddress;
                  wait_cnt <= '0;
               end
            end
            MEM_WAIT: begin
               wait_cnt <= wait_cnt + WAIT_W'(1);
               if (iMemValid) data_q <= iMemData;
               if (iFlush)    pending <= 1'b1;
            end
            FILL: begin
               if (iFlush) pending <= 1'b1;
            end
            FLUSH: begin
               flush_cnt <= flush_cnt + INDEX_WIDTH'(1);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nx   = state;
      oMemReq    = 1'b0;
      oMemAddr   = '0;
      oFillEn    = 1'b0;
      oFillIndex = '0;
      oFillTag   = '0;
      oFillData  = '0;
      oInvEn     = 1'b0;
      oRespValid = 1'b0;
      oRespData  = '0;
      oStall     = 1'b0;
      oError     = 1'b0;
      case (state)
         IDLE: begin
            // Stall combinationally so the missing instruction never advances.
            oStall = (iReq && !iHit) || iFlush || pending;
            if (iFlush || pending)  state_nx = FLUSH;
            else if (iReq && !iHit) state_nx = MEM_WAIT;
         end
         MEM_WAIT: begin
            oStall   = 1'b1;
            oMemReq  = 1'b1;
            oMemAddr = {addr_q[31:2], 2'b00};
            if (iMemValid) begin
               state_nx = FILL;
            end else if (wait_cnt == WAIT_LAST) begin
               oError   = 1'b1;
               state_nx = IDLE;
            end
         end
         FILL: begin
            oStall     = 1'b1;
            oFillEn    = 1'b1;
            oFillIndex = INDEX_WIDTH'(get_index(addr_q, INDEX_WIDTH));
            oFillTag   = TAG_WIDTH'(get_tag(addr_q, INDEX_WIDTH));
            oFillData  = data_q;
            oRespValid = 1'b1;
            oRespData  = data_q;
            state_nx   = IDLE;
         end
         FLUSH: begin
            oStall     = 1'b1;
            oInvEn     = 1'b1;
            oFillIndex = flush_cnt;
            if (flush_cnt == LAST_INDEX) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   a_fill_inv_exclusive: assert property (@(posedge iCLK) !(oFillEn && oInvEn));

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: directed stimulus queues expected
// output records; a negedge monitor pops and compares whenever outputs are active.
module tb_cache_refill_ctrl;

   typedef struct packed {
      logic        stall;
      logic        memreq;
      logic [31:0] memaddr;
      logic        fillen;
      logic        inven;
      logic [3:0]  idx;
      logic [25:0] tag;
      logic [31:0] fdata;
      logic        respv;
      logic [31:0] rdata;
      logic        err;
   } out_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic [31:0] address;
   logic        hit;
   logic        flush;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_valid;
   logic [31:0] mem_data;
   logic        fill_en;
   logic [3:0]  fill_index;
   logic [25:0] fill_tag;
   logic [31:0] fill_data;
   logic        inv_en;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        stall;
   logic        error;

   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;
   out_t exp_q[$];
   int   cyc_q[$];

   cache_refill_ctrl #(
      .INDEX_WIDTH(4),
      .DATA_WIDTH (32),
      .TAG_WIDTH  (26),
      .MEM_TIMEOUT(255)
   ) dut (
      .iCLK      (clk),
      .iRST      (rst),
      .iReq      (req),
      .iAddress  (address),
      .iHit      (hit),
      .iFlush    (flush),
      .oMemReq   (mem_req),
      .oMemAddr  (mem_addr),
      .iMemValid (mem_valid),
      .iMemData  (mem_data),
      .oFillEn   (fill_en),
      .oFillIndex(fill_index),
      .oFillTag  (fill_tag),
      .oFillData (fill_data),
      .oInvEn    (inv_en),
      .oRespValid(resp_valid),
      .oRespData (resp_data),
      .oStall    (stall),
      .oError    (error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic out_t o_stall();
      out_t r = '0;
      r.stall = 1'b1;
      return r;
   endfunction

   function automatic out_t o_wait(input logic [31:0] a, input logic e);
      out_t r = '0;
      r.stall   = 1'b1;
      r.memreq  = 1'b1;
      r.memaddr = a;
      r.err     = e;
      return r;
   endfunction

   function automatic out_t o_fill(input logic [3:0] i, input logic [25:0] t,
                                   input logic [31:0] d);
      out_t r = '0;
      r.stall  = 1'b1;
      r.fillen = 1'b1;
      r.idx    = i;
      r.tag    = t;
      r.fdata  = d;
      r.respv  = 1'b1;
      r.rdata  = d;
      return r;
   endfunction

   function automatic out_t o_inv(input logic [3:0] i);
      out_t r = '0;
      r.stall = 1'b1;
      r.inven = 1'b1;
      r.idx   = i;
      return r;
   endfunction

   task automatic expect_now(input out_t r);
      exp_q.push_back(r);
      cyc_q.push_back(cyc);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_sweep();
      for (int i = 0; i < 16; i++) begin
         expect_now(o_inv(4'(i)));
         tick();
      end
   endtask

   // Monitor: sample away from the active edge; any active output is an event.
   always @(negedge clk) begin
      out_t act;
      out_t ex;
      act = '{stall, mem_req, mem_addr, fill_en, inv_en, fill_index, fill_tag,
              fill_data, resp_valid, resp_data, error};
      while (cyc_q.size() > 0 && cyc_q[0] < cyc) begin
         n_chk++;
         n_err++;
         $display("FAIL missing_event cyc=%0d required=%h actual=none", cyc_q[0], exp_q[0]);
         void'(exp_q.pop_front());
         void'(cyc_q.pop_front());
      end
      if (act.stall || act.memreq || act.fillen || act.inven || act.respv || act.err) begin
         n_chk++;
         if (cyc_q.size() > 0 && cyc_q[0] == cyc) begin
            ex = exp_q.pop_front();
            void'(cyc_q.pop_front());
            if (act !== ex) begin
               n_err++;
               $display("FAIL output_record cyc=%0d actual=%h required=%h", cyc, act, ex);
            end
         end else begin
            n_err++;
            $display("FAIL unexpected_event cyc=%0d actual=%h required=idle", cyc, act);
         end
      end
   end

   initial begin
      rst = 1'b1; req = 1'b0; address = '0; hit = 1'b0; flush = 1'b0;
      mem_valid = 1'b0; mem_data = '0;
      tick(); tick();
      rst = 1'b0;
      tick(); tick();

      // Miss refill, memory answers in the third wait cycle.
      req = 1'b1; address = 32'h0000_1234;
      expect_now(o_stall()); tick();
      req = 1'b0;
      expect_now(o_wait(32'h0000_1234, 1'b0)); tick();
      expect_now(o_wait(32'h0000_1234, 1'b0)); tick();
      mem_valid = 1'b1; mem_data = 32'hDEAD_BEEF;
      expect_now(o_wait(32'h0000_1234, 1'b0)); tick();
      mem_valid = 1'b0; mem_data = '0;
      expect_now(o_fill(4'hD, 26'h000048, 32'hDEAD_BEEF)); tick();

      // Re-presented address now hits: nothing may happen.
      req = 1'b1; hit = 1'b1;
      repeat (4) tick();
      req = 1'b0; hit = 1'b0;
      tick();

      // One-cycle flush pulse in IDLE.
      flush = 1'b1;
      expect_now(o_stall()); tick();
      flush = 1'b0;
      expect_sweep();
      tick(); tick();

      // Flush arriving mid-refill is deferred until after the fill.
      req = 1'b1; address = 32'h0000_ABC8;
      expect_now(o_stall()); tick();
      req = 1'b0; flush = 1'b1;
      expect_now(o_wait(32'h0000_ABC8, 1'b0)); tick();
      flush = 1'b0; mem_valid = 1'b1; mem_data = 32'h1234_5678;
      expect_now(o_wait(32'h0000_ABC8, 1'b0)); tick();
      mem_valid = 1'b0; mem_data = '0;
      expect_now(o_fill(4'h2, 26'h00002AF, 32'h1234_5678)); tick();
      expect_now(o_stall()); tick();
      expect_sweep();
      tick(); tick();

      // Memory never answers: abort after the timeout, then a late valid is ignored.
      req = 1'b1; address = 32'hFFFF_FFFF;
      expect_now(o_stall()); tick();
      req = 1'b0;
      for (int i = 0; i < 255; i++) begin
         expect_now(o_wait(32'hFFFF_FFFC, (i == 254) ? 1'b1 : 1'b0));
         tick();
      end
      tick();
      mem_valid = 1'b1; mem_data = 32'hBAD0_BAD0;
      tick();
      mem_valid = 1'b0; mem_data = '0;
      tick(); tick();

      // Reset in MEM_WAIT aborts the refill; a later valid must not fill.
      req = 1'b1; address = 32'h0000_0040;
      expect_now(o_stall()); tick();
      req = 1'b0;
      expect_now(o_wait(32'h0000_0040, 1'b0)); tick();
      rst = 1'b1;
      expect_now(o_wait(32'h0000_0040, 1'b0)); tick();
      rst = 1'b0;
      tick();
      mem_valid = 1'b1; mem_data = 32'h5555_AAAA;
      tick();
      mem_valid = 1'b0; mem_data = '0;
      repeat (4) tick();

      n_chk++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain actual=%0d required=0 entries left", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
- Miss-handling controller sitting directly downstream of the direct-mapped cache, between the cache arrays and main memory.
- On a load miss it stalls the pipeline, fetches the word from main memory over a request/valid handshake, and writes data, tag and valid bit into the cache.
- It also sequences a full-cache flush by sweeping every index and invalidating it, one index per cycle.

Parameters:
- INDEX_WIDTH, 4, cache index bits; the cache has 2**INDEX_WIDTH lines.
- DATA_WIDTH, 32, cache line and memory word width.
- TAG_WIDTH, 32-INDEX_WIDTH-2, tag bits; 26 at default.
- MEM_TIMEOUT, 255, maximum cycles to wait for iMemValid before aborting a refill.

Ports:
- iCLK  in  1  clock
- iRST  in  1  synchronous reset, active-high
- iReq  in  1  pipeline load request valid this cycle
- iAddress  in  32  load byte address; index = [INDEX_WIDTH+1:2], tag = [31:INDEX_WIDTH+2]
- iHit  in  1  cache tag match AND valid for iAddress, from the cache
- iFlush  in  1  flush request, level-sampled
- oMemReq  in→out  1  read request to main memory
- oMemAddr  out  32  word-aligned memory address, [1:0]=0
- iMemValid  in  1  memory data valid, one-cycle pulse
- iMemData  in  DATA_WIDTH  memory read data
- oFillEn  out  1  write data, tag and valid=1 into the cache at oFillIndex
- oFillIndex  out  INDEX_WIDTH  fill or invalidate index
- oFillTag  out  TAG_WIDTH  fill tag
- oFillData  out  DATA_WIDTH  fill data
- oInvEn  out  1  clear the valid bit at oFillIndex
- oRespValid  out  1  refilled data available to the pipeline this cycle
- oRespData  out  DATA_WIDTH  refilled data
- oStall  out  1  pipeline stall
- oError  out  1  one-cycle pulse on memory timeout

Note: oMemReq direction is out.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs become 0.
  - The wait counter, flush counter, pending-flush flag and latched address are cleared.
  - A reset mid-refill or mid-flush aborts immediately: oMemReq drops on the next edge, and any late iMemValid is ignored.
- States: IDLE, MEM_WAIT, FILL, FLUSH.
- IDLE:
  - If iFlush or the pending-flush flag is set: go to FLUSH and clear pending. Flush has priority over iReq.
  - Else if iReq && !iHit: latch iAddress and go to MEM_WAIT.
  - Else if iReq && iHit: stay in IDLE; no action (the cache serves the data).
- MEM_WAIT:
  - oMemReq=1 and oMemAddr = {latched[31:2],2'b00}, both held stable until iMemValid.
  - The wait counter increments each cycle.
  - On iMemValid: register iMemData and go to FILL.
  - If the counter reaches MEM_TIMEOUT without iMemValid: pulse oError for 1 cycle, make no cache write, go to IDLE.
  - iFlush asserted here sets the pending-flush flag.
- FILL, exactly 1 cycle:
  - oFillEn=1.
  - oFillIndex = latched index; oFillTag = latched tag; oFillData = captured data.
  - oRespValid=1 and oRespData = captured data.
  - Then go to IDLE.
  - iFlush here also sets pending.
- FLUSH:
  - The counter runs from 0 to 2**INDEX_WIDTH-1.
  - oInvEn=1 and oFillIndex = counter each cycle; oFillEn=0.
  - After the last index, go to IDLE.
  - Takes exactly 2**INDEX_WIDTH cycles (16 at default).
  - iFlush during FLUSH is ignored and does not re-arm.
- Stall rule:
  - oStall = (state != IDLE) || (state==IDLE && ((iReq && !iHit) || iFlush || pending)).
  - This is combinational in IDLE so the missing instruction never advances.
  - oStall is low in the cycle after FILL. The pipeline re-presents the address and it hits.
- Miss latency: request cycle, then MEM_WAIT for N cycles until iMemValid, then FILL. Total stall = N+2 cycles.
- iMemValid outside MEM_WAIT is ignored.
- oFillEn and oInvEn are never both 1.
- The wait counter is wide enough for MEM_TIMEOUT; it resets on entry to MEM_WAIT.

Decomposition:
- cache_pkg holds:
  - the state enum (IDLE, MEM_WAIT, FILL, FLUSH);
  - the INDEX_WIDTH, TAG_WIDTH and OFFSET_WIDTH=2 constants;
  - functions get_index(addr) and get_tag(addr), shared with the cache module.
- No sub-module is required. The flush sweep counter and timeout counter stay inline.

Test Plan:
- Miss refill:
  - Stimulus: iReq=1, iHit=0, iAddress=0x0000_1234; memory returns iMemValid with 0xDEADBEEF after 3 cycles.
  - Required: oMemReq held high with oMemAddr=0x0000_1234 for 3 cycles; then one FILL cycle with oFillEn=1, oFillIndex=0xD, oFillTag=0x000048, oFillData=oRespData=0xDEADBEEF; oStall high for 5 cycles total.
- Hit:
  - Stimulus: iReq=1, iHit=1.
  - Required: oStall=0, oMemReq=0, oFillEn=0 on every cycle.
- Flush:
  - Stimulus: 1-cycle iFlush pulse in IDLE.
  - Required: oInvEn=1 for 16 consecutive cycles with oFillIndex 0..15; oStall high throughout; then IDLE.
- Flush during refill:
  - Stimulus: iFlush asserted in MEM_WAIT.
  - Required: the refill completes (FILL cycle seen), then the 16-cycle sweep starts in the following IDLE cycle.
- Timeout:
  - Stimulus: no iMemValid for MEM_TIMEOUT cycles.
  - Required: oError pulses once; no oFillEn; return to IDLE. A late iMemValid afterwards is ignored.
- Reset mid-refill:
  - Stimulus: iRST asserted in MEM_WAIT.
  - Required: all outputs 0 next cycle; a following iMemValid produces no oFillEn.
